// File: rtl/connect_pkg.sv
// connect_pkg
// Shared definitions for the connect-N board engine: cell encodings, the
// engine FSM state type and the neighbour-walk direction table.
package connect_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PLACE,
        WALK_POS,
        WALK_NEG,
        NEXT_DIR,
        DONE
    } state_t;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } delta_t;

    // Row 0 is the top of the board, so +dr walks downwards.
    // 0 horizontal, 1 vertical, 2 diagonal (up-right), 3 anti-diagonal (down-right)
    function automatic delta_t dir_delta(input logic [1:0] d);
        case (d)
            2'd0:    dir_delta = '{dr: 2'sd0,  dc: 2'sd1};
            2'd1:    dir_delta = '{dr: 2'sd1,  dc: 2'sd0};
            2'd2:    dir_delta = '{dr: -2'sd1, dc: 2'sd1};
            default: dir_delta = '{dr: 2'sd1,  dc: 2'sd1};
        endcase
    endfunction

endpackage

// File: rtl/connect_board_store.sv
// connect_board_store
// Token board storage with one write port and two combinational read ports
// (walker and VGA), per-column fill heights and a total piece counter.
// Ports:
//   CLOCK_50, Resetn        clock, async active-low reset
//   clear                   synchronous empty of board/heights/count
//   we, we_row/col/cell     single write port; also bumps height and count
//   ht_col -> ht            combinational height of a column (0 if out of range)
//   count                   number of tokens on the board
//   wk_row/col -> wk_cell   walker read port
//   rd_row/col -> rd_cell   VGA read port
// Both read ports return EMPTY for out-of-range indices.
module connect_board_store
    import connect_pkg::*;
#(
    parameter int COLS  = 7,
    parameter int ROWS  = 6,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS),
    parameter int CNT_W = $clog2(ROWS*COLS+1)
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    input  logic             clear,
    input  logic             we,
    input  logic [ROW_W-1:0] we_row,
    input  logic [COL_W-1:0] we_col,
    input  logic [1:0]       we_cell,
    input  logic [COL_W-1:0] ht_col,
    output logic [ROW_W:0]   ht,
    output logic [CNT_W-1:0] count,
    input  logic [ROW_W-1:0] wk_row,
    input  logic [COL_W-1:0] wk_col,
    output logic [1:0]       wk_cell,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [1:0]       rd_cell
);

    logic [1:0]       cells   [ROWS][COLS];
    logic [ROW_W:0]   heights [COLS];
    logic [CNT_W-1:0] pieces;

    function automatic logic row_ok(input logic [ROW_W-1:0] r);
        return {1'b0, r} < (ROW_W+1)'(ROWS);
    endfunction

    function automatic logic col_ok(input logic [COL_W-1:0] c);
        return {1'b0, c} < (COL_W+1)'(COLS);
    endfunction

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    cells[r][c] <= EMPTY;
            for (int c = 0; c < COLS; c++)
                heights[c] <= '0;
            pieces <= '0;
        end else if (clear) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    cells[r][c] <= EMPTY;
            for (int c = 0; c < COLS; c++)
                heights[c] <= '0;
            pieces <= '0;
        end else if (we) begin
            cells[we_row][we_col] <= we_cell;
            heights[we_col]       <= heights[we_col] + (ROW_W+1)'(1);
            pieces                <= pieces + CNT_W'(1);
        end
    end

    assign ht      = col_ok(ht_col) ? heights[ht_col] : '0;
    assign count   = pieces;
    assign wk_cell = (row_ok(wk_row) && col_ok(wk_col)) ? cells[wk_row][wk_col] : EMPTY;
    assign rd_cell = (row_ok(rd_row) && col_ok(rd_col)) ? cells[rd_row][rd_col] : EMPTY;

endmodule

// File: rtl/connect_n_engine.sv
// connect_n_engine
// Accepts drop requests over valid/ready, places the token in the lowest free
// row of the column and scans for a WIN_LEN line by walking one neighbour cell
// per cycle in each of four directions. Reports reject, win, draw and sticky
// game-over, and exposes the board to the VGA drawer through rd_*.
// Ports:
//   CLOCK_50, Resetn                   clock, async active-low reset
//   clear                              synchronous new game, aborts any scan
//   drop_valid/drop_ready              request handshake (ready only in IDLE)
//   drop_col, drop_player              target column, 0=P1 1=P2
//   done                               one-cycle result pulse
//   accepted, placed_row, win, draw    results, held until next done or clear
//   game_over                          sticky until clear or reset
//   rd_col, rd_row -> rd_cell          combinational board read
//
// state    | meaning
// IDLE     | waiting for a drop, drop_ready high
// CHECK    | reject on bad column, full column or game over
// PLACE    | write token, start walk in direction 0
// WALK_POS | step +delta, count matching cells
// WALK_NEG | step -delta from the placed cell, count matching cells
// NEXT_DIR | reset run, advance direction or finish after direction 3
// DONE     | publish results, pulse done, back to IDLE
module connect_n_engine
    import connect_pkg::*;
#(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4,
    parameter int COL_W   = $clog2(COLS),
    parameter int ROW_W   = $clog2(ROWS)
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    input  logic             clear,
    input  logic             drop_valid,
    output logic             drop_ready,
    input  logic [COL_W-1:0] drop_col,
    input  logic             drop_player,
    output logic             done,
    output logic             accepted,
    output logic [ROW_W-1:0] placed_row,
    output logic             win,
    output logic             draw,
    output logic             game_over,
    input  logic [COL_W-1:0] rd_col,
    input  logic [ROW_W-1:0] rd_row,
    output logic [1:0]       rd_cell
);

    localparam int CNT_W = $clog2(ROWS*COLS+1);
    localparam int RUN_W = $clog2(WIN_LEN+1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(ROWS*COLS);

    state_t                  state;
    logic [1:0]              dir;
    logic [RUN_W-1:0]        run;
    logic [COL_W-1:0]        col_q;
    logic                    player_q;
    logic [ROW_W-1:0]        row_q;
    logic signed [ROW_W:0]   wr;
    logic signed [COL_W:0]   wc;
    logic                    acc_q;
    logic                    win_q;

    logic [ROW_W:0]          ht;
    logic [CNT_W-1:0]        count;
    logic [1:0]              wk_cell;
    logic [1:0]              my_cell;
    logic [ROW_W-1:0]        new_row;
    logic                    col_bad;
    logic                    on_board;
    logic                    step_match;
    logic                    run_hits_win;
    logic                    draw_now;
    logic signed [ROW_W:0]   row_s;
    logic signed [ROW_W:0]   new_row_s;
    logic signed [COL_W:0]   col_s;
    delta_t                  d_first;
    delta_t                  d_cur;
    delta_t                  d_next;

    function automatic logic signed [ROW_W:0] ext_r(input logic signed [1:0] v);
        return (ROW_W+1)'(v);
    endfunction

    function automatic logic signed [COL_W:0] ext_c(input logic signed [1:0] v);
        return (COL_W+1)'(v);
    endfunction

    assign my_cell   = player_q ? P2 : P1;
    assign new_row   = ROW_W'(ROWS-1) - ht[ROW_W-1:0];
    assign col_bad   = {1'b0, col_q} >= (COL_W+1)'(COLS);
    assign row_s     = $signed({1'b0, row_q});
    assign new_row_s = $signed({1'b0, new_row});
    assign col_s     = $signed({1'b0, col_q});
    assign d_first   = dir_delta(2'd0);
    assign d_cur     = dir_delta(dir);
    assign d_next    = dir_delta(dir + 2'd1);

    // Walk coordinates carry a sign bit, so stepping past either edge shows
    // up as negative or >= size instead of wrapping onto a real cell.
    assign on_board = !wr[ROW_W] && !wc[COL_W]
                      && ({1'b0, wr[ROW_W-1:0]} < (ROW_W+1)'(ROWS))
                      && ({1'b0, wc[COL_W-1:0]} < (COL_W+1)'(COLS));
    assign step_match   = on_board && (wk_cell == my_cell);
    assign run_hits_win = (run + RUN_W'(1)) == RUN_W'(WIN_LEN);
    assign draw_now     = acc_q && !win_q && (count == FULL_COUNT);

    connect_board_store #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W),
        .CNT_W (CNT_W)
    ) u_store (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .clear    (clear),
        .we       (state == PLACE),
        .we_row   (new_row),
        .we_col   (col_q),
        .we_cell  (my_cell),
        .ht_col   (col_q),
        .ht       (ht),
        .count    (count),
        .wk_row   (wr[ROW_W-1:0]),
        .wk_col   (wc[COL_W-1:0]),
        .wk_cell  (wk_cell),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_cell  (rd_cell)
    );

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state      <= IDLE;
            dir        <= '0;
            run        <= '0;
            col_q      <= '0;
            player_q   <= 1'b0;
            row_q      <= '0;
            wr         <= '0;
            wc         <= '0;
            acc_q      <= 1'b0;
            win_q      <= 1'b0;
            drop_ready <= 1'b0;
            done       <= 1'b0;
            accepted   <= 1'b0;
            placed_row <= '0;
            win        <= 1'b0;
            draw       <= 1'b0;
            game_over  <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            drop_ready <= 1'b1;
            done       <= 1'b0;
            accepted   <= 1'b0;
            placed_row <= '0;
            win        <= 1'b0;
            draw       <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    drop_ready <= 1'b1;
                    if (drop_valid && drop_ready) begin
                        col_q      <= drop_col;
                        player_q   <= drop_player;
                        drop_ready <= 1'b0;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (col_bad || (ht == (ROW_W+1)'(ROWS)) || game_over) begin
                        acc_q <= 1'b0;
                        win_q <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= PLACE;
                    end
                end
                PLACE: begin
                    row_q <= new_row;
                    acc_q <= 1'b1;
                    win_q <= 1'b0;
                    run   <= RUN_W'(1);
                    dir   <= 2'd0;
                    wr    <= new_row_s + ext_r(d_first.dr);
                    wc    <= col_s + ext_c(d_first.dc);
                    state <= WALK_POS;
                end
                WALK_POS: begin
                    if (step_match) begin
                        if (run_hits_win) begin
                            win_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            run <= run + RUN_W'(1);
                            wr  <= wr + ext_r(d_cur.dr);
                            wc  <= wc + ext_c(d_cur.dc);
                        end
                    end else begin
                        wr    <= row_s - ext_r(d_cur.dr);
                        wc    <= col_s - ext_c(d_cur.dc);
                        state <= WALK_NEG;
                    end
                end
                WALK_NEG: begin
                    if (step_match) begin
                        if (run_hits_win) begin
                            win_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            run <= run + RUN_W'(1);
                            wr  <= wr - ext_r(d_cur.dr);
                            wc  <= wc - ext_c(d_cur.dc);
                        end
                    end else begin
                        state <= NEXT_DIR;
                    end
                end
                NEXT_DIR: begin
                    if (dir == 2'd3) begin
                        state <= DONE;
                    end else begin
                        dir   <= dir + 2'd1;
                        run   <= RUN_W'(1);
                        wr    <= row_s + ext_r(d_next.dr);
                        wc    <= col_s + ext_c(d_next.dc);
                        state <= WALK_POS;
                    end
                end
                DONE: begin
                    done       <= 1'b1;
                    accepted   <= acc_q;
                    win        <= win_q;
                    draw       <= draw_now;
                    game_over  <= game_over | win_q | draw_now;
                    placed_row <= acc_q ? row_q : '0;
                    drop_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_connect_n_engine.sv
// tb_connect_n_engine
// Table-driven bench: each record is one drop (optionally preceded by a
// clear) with hand-computed results, followed by hand-written sequences for
// clear and reset during a scan.
module tb_connect_n_engine;

    logic       CLOCK_50;
    logic       Resetn;
    logic       clear;
    logic       drop_valid;
    logic       drop_ready;
    logic [2:0] drop_col;
    logic       drop_player;
    logic       done;
    logic       accepted;
    logic [2:0] placed_row;
    logic       win;
    logic       draw;
    logic       game_over;
    logic [2:0] rd_col;
    logic [2:0] rd_row;
    logic [1:0] rd_cell;

    int errors = 0;
    int checks = 0;
    int shadow [6][7];

    typedef struct {
        bit clr;
        int col;
        int player;
        int exp_acc;
        int exp_row;
        int exp_win;
        int exp_draw;
        int exp_go;
        int exp_lat;   // -1: only bounded by 27
    } vec_t;

    vec_t vecs[$];

    connect_n_engine dut (
        .CLOCK_50    (CLOCK_50),
        .Resetn      (Resetn),
        .clear       (clear),
        .drop_valid  (drop_valid),
        .drop_ready  (drop_ready),
        .drop_col    (drop_col),
        .drop_player (drop_player),
        .done        (done),
        .accepted    (accepted),
        .placed_row  (placed_row),
        .win         (win),
        .draw        (draw),
        .game_over   (game_over),
        .rd_col      (rd_col),
        .rd_row      (rd_row),
        .rd_cell     (rd_cell)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    function automatic void add(bit clr, int col, int player, int acc, int row,
                                int w, int d, int go, int lat);
        vec_t v;
        v.clr = clr; v.col = col; v.player = player; v.exp_acc = acc;
        v.exp_row = row; v.exp_win = w; v.exp_draw = d; v.exp_go = go;
        v.exp_lat = lat;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic rd(input int r, input int c, output int val);
        rd_row = r[2:0];
        rd_col = c[2:0];
        #1;
        val = int'(rd_cell);
    endtask

    task automatic realign();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Compare every on-board cell against the shadow board; one check.
    task automatic check_board(input string name);
        int v;
        int bad;
        int first_r;
        int first_c;
        int first_v;
        bad = 0; first_r = 0; first_c = 0; first_v = 0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) begin
                rd(r, c, v);
                if (v != shadow[r][c]) begin
                    if (bad == 0) begin first_r = r; first_c = c; first_v = v; end
                    bad++;
                end
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d cells differ, first (%0d,%0d) got %0d expected %0d",
                     name, bad, first_r, first_c, first_v, shadow[first_r][first_c]);
        end
    endtask

    task automatic clear_shadow();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                shadow[r][c] = 0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        realign();
        clear = 1'b0;
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!drop_ready && guard < 50) begin
            realign();
            guard++;
        end
        if (!drop_ready) chk("ready_timeout", 0, 1);
    endtask

    // Handshake happens on the first edge after driving; lat counts edges
    // from that handshake edge until done is seen high.
    task automatic do_drop(input int col, input int player, output int lat, output bit timeout);
        wait_ready();
        drop_col    = col[2:0];
        drop_player = player[0];
        drop_valid  = 1'b1;
        realign();
        drop_valid  = 1'b0;
        lat = 0;
        timeout = 1'b0;
        while (!done) begin
            if (lat >= 60) begin
                timeout = 1'b1;
                break;
            end
            realign();
            lat++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_done"},       int'(done),       0);
        chk({tag, "_accepted"},   int'(accepted),   0);
        chk({tag, "_win"},        int'(win),        0);
        chk({tag, "_draw"},       int'(draw),       0);
        chk({tag, "_game_over"},  int'(game_over),  0);
        chk({tag, "_placed_row"}, int'(placed_row), 0);
        chk({tag, "_drop_ready"}, int'(drop_ready), 0);
    endtask

    initial begin
        int lat;
        bit to;
        int v;
        int seen;
        vec_t t;

        Resetn = 1'b0; clear = 1'b0; drop_valid = 1'b0; drop_col = '0;
        drop_player = 1'b0; rd_col = '0; rd_row = '0;
        clear_shadow();

        // 1: single drop into empty board
        add(0, 3, 0, 1, 5, 0, 0, 0, -1);
        // 2: horizontal P1 win on bottom row, P2 stacking col 6, then reject
        add(1, 0, 0, 1, 5, 0, 0, 0, -1);
        add(0, 6, 1, 1, 5, 0, 0, 0, -1);
        add(0, 1, 0, 1, 5, 0, 0, 0, -1);
        add(0, 6, 1, 1, 4, 0, 0, 0, -1);
        add(0, 2, 0, 1, 5, 0, 0, 0, -1);
        add(0, 6, 1, 1, 3, 0, 0, 0, -1);
        add(0, 3, 0, 1, 5, 1, 0, 1, -1);
        add(0, 4, 1, 0, 0, 0, 0, 1, 2);
        // 3: fill col 2, then full-column and out-of-range rejects
        add(1, 2, 0, 1, 5, 0, 0, 0, -1);
        add(0, 2, 1, 1, 4, 0, 0, 0, -1);
        add(0, 2, 0, 1, 3, 0, 0, 0, -1);
        add(0, 2, 1, 1, 2, 0, 0, 0, -1);
        add(0, 2, 0, 1, 1, 0, 0, 0, -1);
        add(0, 2, 1, 1, 0, 0, 0, 0, -1);
        add(0, 2, 0, 0, 0, 0, 0, 0, 2);
        add(0, 7, 1, 0, 0, 0, 0, 0, 2);
        // 4a: P2 diagonal (5,0) (4,1) (3,2) (2,3)
        add(1, 0, 1, 1, 5, 0, 0, 0, -1);
        add(0, 1, 0, 1, 5, 0, 0, 0, -1);
        add(0, 1, 1, 1, 4, 0, 0, 0, -1);
        add(0, 2, 0, 1, 5, 0, 0, 0, -1);
        add(0, 2, 0, 1, 4, 0, 0, 0, -1);
        add(0, 2, 1, 1, 3, 0, 0, 0, -1);
        add(0, 3, 0, 1, 5, 0, 0, 0, -1);
        add(0, 3, 0, 1, 4, 0, 0, 0, -1);
        add(0, 3, 0, 1, 3, 0, 0, 0, -1);
        add(0, 3, 1, 1, 2, 1, 0, 1, -1);
        // 4b: mirrored anti-diagonal (2,3) (3,4) (4,5) (5,6)
        add(1, 6, 1, 1, 5, 0, 0, 0, -1);
        add(0, 5, 0, 1, 5, 0, 0, 0, -1);
        add(0, 5, 1, 1, 4, 0, 0, 0, -1);
        add(0, 4, 0, 1, 5, 0, 0, 0, -1);
        add(0, 4, 0, 1, 4, 0, 0, 0, -1);
        add(0, 4, 1, 1, 3, 0, 0, 0, -1);
        add(0, 3, 0, 1, 5, 0, 0, 0, -1);
        add(0, 3, 0, 1, 4, 0, 0, 0, -1);
        add(0, 3, 0, 1, 3, 0, 0, 0, -1);
        add(0, 3, 1, 1, 2, 1, 0, 1, -1);
        // 5: full board, player = ((r/2)+c) odd -> no run longer than 2
        for (int c = 0; c < 7; c++)
            for (int r = 5; r >= 0; r--) begin
                bit last;
                last = (c == 6) && (r == 0);
                add((c == 0) && (r == 5), c, ((r / 2) + c) % 2, 1, r,
                    0, int'(last), int'(last), -1);
            end
        add(0, 0, 0, 0, 0, 0, 0, 1, 2);

        // Reset state
        #35;
        check_outputs_zero("reset");
        check_board("reset_board");
        #5 Resetn = 1'b1;
        realign();
        chk("ready_after_reset", int'(drop_ready), 1);

        foreach (vecs[i]) begin
            t = vecs[i];
            if (t.clr) begin
                do_clear();
                clear_shadow();
            end
            do_drop(t.col, t.player, lat, to);
            if (to) begin
                chk($sformatf("v%0d_done_timeout", i), 1, 0);
            end else begin
                if (t.exp_lat < 0)
                    chk($sformatf("v%0d_latency_le27(lat=%0d)", i, lat), int'(lat <= 27), 1);
                else
                    chk($sformatf("v%0d_latency", i), lat, t.exp_lat);
                chk($sformatf("v%0d_accepted", i),   int'(accepted),   t.exp_acc);
                chk($sformatf("v%0d_win", i),        int'(win),        t.exp_win);
                chk($sformatf("v%0d_draw", i),       int'(draw),       t.exp_draw);
                chk($sformatf("v%0d_game_over", i),  int'(game_over),  t.exp_go);
                chk($sformatf("v%0d_ready_at_done", i), int'(drop_ready), 1);
                if (t.exp_acc != 0) begin
                    chk($sformatf("v%0d_placed_row", i), int'(placed_row), t.exp_row);
                    shadow[t.exp_row][t.col] = t.player + 1;
                end
                realign();
                chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
                check_board($sformatf("v%0d_board", i));
                realign();
            end
        end

        // Out-of-range reads on a full board
        rd(6, 3, v); chk("rd_row_oob", v, 0);
        rd(2, 7, v); chk("rd_col_oob", v, 0);
        rd(7, 7, v); chk("rd_both_oob", v, 0);
        realign();

        // Clear mid-scan
        do_clear();
        clear_shadow();
        do_drop(0, 0, lat, to);
        chk("pre_clear_accepted", int'(accepted), 1);
        realign();
        wait_ready();
        drop_col = 3'd1; drop_player = 1'b0; drop_valid = 1'b1;
        realign();
        drop_valid = 1'b0;
        repeat (4) realign();
        clear = 1'b1;
        realign();
        clear = 1'b0;
        chk("clear_ready_next", int'(drop_ready), 1);
        chk("clear_accepted",   int'(accepted),   0);
        chk("clear_placed_row", int'(placed_row), 0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) seen++;
            realign();
        end
        chk("clear_no_done", seen, 0);
        chk("clear_game_over", int'(game_over), 0);
        check_board("clear_board");
        realign();

        // Reset mid-scan
        do_drop(0, 0, lat, to);
        chk("pre_reset_accepted", int'(accepted), 1);
        chk("pre_reset_row", int'(placed_row), 5);
        realign();
        wait_ready();
        drop_col = 3'd0; drop_player = 1'b0; drop_valid = 1'b1;
        realign();
        drop_valid = 1'b0;
        repeat (4) realign();
        #3 Resetn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        clear_shadow();
        check_board("midreset_board");
        #2 Resetn = 1'b1;
        realign();
        chk("ready_after_midreset", int'(drop_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
